// File: rtl/fetch_queue.sv
// fetch_queue: in-order {PC+4, instruction} queue feeding decode; show-ahead head, 1-cycle push-to-output latency.
// Backpressure: PCWriteEnable drops only when full and decode stalls; FETCH_QUEUE_STATS_EN adds stall/flush/retire counters.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [31:0]   PC,
    input  logic [31:0]   Instruction,
    input  logic          FetchValid,
    input  logic          DecodeReady,
    input  logic          Flush,
    output logic [31:0]   InstructionOut,
    output logic [31:0]   PCPlus4Out,
    output logic          OutValid,
    output logic          PCWriteEnable,
    output logic [AW:0]   Count
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]   StallCycles,
    output logic [31:0]   FlushedEntries,
    output logic [31:0]   RetiredCount
`endif
);

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc4_mem   [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign pop   = OutValid & DecodeReady & ~Flush;
    assign push  = FetchValid & ~Flush & (~full | pop);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (Flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge Clock) begin
        if (push) begin
            instr_mem[wr_ptr] <= Instruction;
            pc4_mem[wr_ptr]   <= PC + 32'd4;
        end
    end

    assign OutValid       = ~empty;
    assign InstructionOut = empty ? 32'h0 : instr_mem[rd_ptr];
    assign PCPlus4Out     = empty ? 32'h0 : pc4_mem[rd_ptr];
    assign PCWriteEnable  = Flush | ~full | (OutValid & DecodeReady);
    assign Count          = count;

`ifdef FETCH_QUEUE_STATS_EN
    logic stall_blk;
    assign stall_blk = FetchValid & ~Flush & full & ~pop;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            StallCycles    <= '0;
            FlushedEntries <= '0;
            RetiredCount   <= '0;
        end else begin
            if (stall_blk)
                StallCycles <= StallCycles + 32'd1;
            if (Flush)
                FlushedEntries <= FlushedEntries + 32'(count);
            if (pop)
                RetiredCount <= RetiredCount + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch queue directly downstream of the program counter register.
- Captures each fetched instruction with its PC+4 and presents them to decode in order.
- Absorbs decode stalls and drops wrong-path fetches on a branch/jump redirect (flush).
- Drives the PC register's write-enable, so the PC advances only when the queue can accept the next fetch.

Parameters:
- DEPTH, 2, number of queue entries; power of two, minimum 2.
- AW, 1, pointer width, equal to log2(DEPTH).

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  reset, asynchronous, active-high.
- PC  input  32  current PC from the PC register.
- Instruction  input  32  instruction memory read data for PC (combinational, same cycle).
- FetchValid  input  1  Instruction is valid this cycle.
- DecodeReady  input  1  decode consumes the head entry this cycle.
- Flush  input  1  redirect; discard all queued and in-flight fetches.
- InstructionOut  output  32  head instruction; 0x00000000 (NOP) when empty.
- PCPlus4Out  output  32  PC+4 of the head instruction; 0 when empty.
- OutValid  output  1  head entry valid.
- PCWriteEnable  output  1  write-enable to the PC register.
- Count  output  AW+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Reset (async, any time, including mid-operation):
  - read/write pointers, Count and all entry valid state go to 0.
  - OutValid=0, InstructionOut=0, PCPlus4Out=0.
  - Storage contents are don't-care.
- Entry format: {PC+4, Instruction}.
  - PC+4 is computed modulo 2^32; 0xFFFFFFFC gives 0x00000000.
- push = FetchValid & ~Flush & (~Full | pop).
- pop = OutValid & DecodeReady & ~Flush.
- Full = (Count==DEPTH); Empty = (Count==0).
- Show-ahead output: InstructionOut, PCPlus4Out and OutValid reflect the entry at the read pointer combinationally from registered state.
  - Empty forces InstructionOut=0, PCPlus4Out=0, OutValid=0.
- Latency: an entry pushed on rising edge N is visible at the output after edge N (one cycle).
  - No combinational bypass from Instruction to InstructionOut.
- Simultaneous push and pop:
  - Count unchanged; both pointers advance.
  - Legal when full. Legal when empty only if OutValid=1, which is impossible, so on empty only the push occurs.
- Pop on empty: ignored; no pointer movement and no underflow.
- Push when full without pop: blocked. PCWriteEnable is 0 in that case, so the PC holds and the same fetch is re-presented next cycle.
- Pointers wrap modulo DEPTH; Count never exceeds DEPTH.
- PCWriteEnable = Flush | ~Full | (OutValid & DecodeReady).
  - Deasserts only when the queue is full and decode is stalled.
- Flush (synchronous, highest priority after Reset):
  - On the edge: Count=0 and pointers=0; push and pop are suppressed that cycle.
  - The next cycle shows OutValid=0.
  - PCWriteEnable=1 during Flush so the redirect target loads into the PC.
- FetchValid=0: no push; PCWriteEnable still follows the rule above.

Optional Feature:
- Macro: FETCH_QUEUE_STATS_EN.
- When defined, adds three outputs:
  - StallCycles (32): increments every cycle that FetchValid=1 and the push is blocked by Full.
  - FlushedEntries (32): adds the pre-flush Count on each Flush edge.
  - RetiredCount (32): increments on each pop.
- All three reset to 0, wrap modulo 2^32, and hold their value across Flush.
- When not defined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-stream with Count=2 -> same cycle: OutValid=0, InstructionOut=0, Count=0, PCWriteEnable=1.
- DecodeReady=1 throughout, PC=0,4,8 with Instruction=0x20080001,0x20090002,0x01095020 -> one cycle later the outputs stream (0x20080001,4), (0x20090002,8), (0x01095020,12); Count stays ≤1.
- DecodeReady=0, FetchValid=1 for 3 cycles with PC=0,4,8 -> Count=2, PCWriteEnable=0 on the third cycle, head=(instr@0, PCPlus4Out=4). Then raise DecodeReady -> head (instr@4, 8), instr@8 accepted, Count stays 2.
- Full queue plus Flush with FetchValid=1 -> next cycle Count=0, OutValid=0, InstructionOut=0; PCWriteEnable=1 during the Flush cycle; the next fetch (PC=0x40) appears alone with PCPlus4Out=0x44.
- PC=0xFFFFFFFC pushed -> PCPlus4Out=0x00000000; pointer wrap exercised over 5 push/pop pairs with no Count drift.
- With FETCH_QUEUE_STATS_EN: 3 blocked fetch cycles, one Flush at Count=2, then 4 pops -> StallCycles=3, FlushedEntries=2, RetiredCount=4.
